// File: rtl/bp_sac_flit_deserializer.sv
// Wormhole flit deserializer: collects a header plus len body flits into one wide message.
// Optional BP_SAC_DESER_LEN_CHECK_EN adds err_o and a DRAIN state for oversize headers.
module bp_sac_flit_deserializer #(
    parameter int flit_width_p = 64,
    parameter int max_flits_p  = 4,
    parameter int cord_width_p = 8,
    parameter int len_width_p  = 3
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [flit_width_p-1:0]             link_data_i,
    input  logic                                link_v_i,
    output logic                                link_ready_and_o,
    output logic [flit_width_p*max_flits_p-1:0] msg_o,
    output logic [len_width_p-1:0]              msg_len_o,
    output logic                                msg_v_o,
    input  logic                                msg_ready_and_i
`ifdef BP_SAC_DESER_LEN_CHECK_EN
    ,
    output logic                                err_o
`endif
);

`ifdef BP_SAC_DESER_LEN_CHECK_EN
    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT, DRAIN} state_e;
    localparam logic [len_width_p:0] max_len_lp = (len_width_p+1)'(max_flits_p-1);
    logic err_r;
`else
    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_e;
`endif

    state_e state_r, state_n;

    logic [max_flits_p-1:0][flit_width_p-1:0] msg_r;
    logic [len_width_p-1:0]                   len_r;
    logic [len_width_p-1:0]                   cnt_r;
    logic [len_width_p-1:0]                   hdr_len;
    logic                                     link_xfer;
    logic                                     msg_xfer;
    logic                                     last;

    assign hdr_len   = link_data_i[cord_width_p +: len_width_p];
    assign link_xfer = link_v_i & link_ready_and_o;
    assign msg_xfer  = msg_v_o & msg_ready_and_i;
    assign last      = (cnt_r == len_r);

    assign msg_o     = msg_r;
    assign msg_len_o = len_r;
`ifdef BP_SAC_DESER_LEN_CHECK_EN
    assign err_o     = err_r;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= IDLE;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n          = state_r;
        link_ready_and_o = 1'b0;
        msg_v_o          = 1'b0;
        case (state_r)
            IDLE: begin
                link_ready_and_o = 1'b1;
                if (link_xfer) begin
`ifdef BP_SAC_DESER_LEN_CHECK_EN
                    if ({1'b0, hdr_len} > max_len_lp) state_n = DRAIN;
                    else
`endif
                    if (hdr_len == '0) state_n = OUTPUT;
                    else               state_n = COLLECT;
                end
            end
            COLLECT: begin
                link_ready_and_o = 1'b1;
                if (link_xfer && last) state_n = OUTPUT;
            end
            OUTPUT: begin
                msg_v_o = 1'b1;
                if (msg_xfer) state_n = IDLE;
            end
`ifdef BP_SAC_DESER_LEN_CHECK_EN
            DRAIN: begin
                link_ready_and_o = 1'b1;
                if (link_xfer && last) state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Body flits beyond max_flits_p match no slot and are dropped; the count still advances.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            msg_r <= '0;
            len_r <= '0;
            cnt_r <= '0;
`ifdef BP_SAC_DESER_LEN_CHECK_EN
            err_r <= 1'b0;
`endif
        end else begin
`ifdef BP_SAC_DESER_LEN_CHECK_EN
            err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: if (link_xfer) begin
                    msg_r    <= '0;
                    msg_r[0] <= link_data_i;
                    len_r    <= hdr_len;
                    cnt_r    <= len_width_p'(1);
                end
                COLLECT: if (link_xfer) begin
                    for (int k = 1; k < max_flits_p; k++)
                        if (cnt_r == len_width_p'(k)) msg_r[k] <= link_data_i;
                    cnt_r <= cnt_r + 1'b1;
                end
`ifdef BP_SAC_DESER_LEN_CHECK_EN
                DRAIN: if (link_xfer) begin
                    cnt_r <= cnt_r + 1'b1;
                    if (last) err_r <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
